smem_result_writer: RTL and testbench
=====================================

Name: smem_result_writer

Overview:
- Sits directly downstream of the curr/mem result RAM block.
- Grants that block its output permit, then accepts its 512-bit result lines: a group header line followed by packed mem entries.
- Buffers the lines in a FIFO and issues them as sequential cache-line writes to host memory from a programmed base address.
- Back-pressures the whole pipeline through the shared stall signal, and reports completion once every write has been acknowledged.

Parameters:
- FIFO_DEPTH, 64, result line buffer depth in 512-bit entries; must be a power of two.
- ADDR_WIDTH, 42, cache-line address width of the host write channel.
- AF_MARGIN, 8, free-entry threshold; stall is asserted when fill ≥ FIFO_DEPTH−AF_MARGIN; must be ≥ 3.
- CNT_WIDTH, 20, width of the line and outstanding-write counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; arms the block for one batch
- base_addr  in  ADDR_WIDTH  first cache-line address of the batch; sampled on start
- output_request  in  1  upstream has finished its batch and wants to drain
- output_permit  out  1  grant to upstream
- output_data  in  512  result line
- output_valid  in  1  output_data is valid
- output_finish  in  1  upstream has emitted its last line; level signal
- stall  out  1  pipeline-wide freeze request
- wr_req_valid  out  1  host write request
- wr_req_addr  out  ADDR_WIDTH  host write cache-line address
- wr_req_data  out  512  host write data
- wr_almost_full  in  1  host channel cannot take requests this cycle
- wr_rsp_valid  in  1  one write acknowledged
- lines_written  out  CNT_WIDTH  requests issued in the current batch
- done  out  1  batch fully written and acknowledged

Behaviour:
- Reset values: output_permit=0, stall=0, wr_req_valid=0, wr_req_addr=0, wr_req_data=0, lines_written=0, done=0. FIFO is emptied, outstanding counter=0, FSM=IDLE.
- Reset mid-batch aborts immediately; no further requests are issued.
- FSM states and transitions:
  - IDLE: on start, latch base_addr into the address pointer, clear lines_written/outstanding/done → WAIT_REQ.
  - WAIT_REQ: on output_request=1 → STREAM, with output_permit=1 from the next cycle.
  - STREAM: output_permit held 1. On capture of output_finish=1 → DRAIN.
  - DRAIN: output_permit held 1. When FIFO empty and outstanding==0 → DONE.
  - DONE: done=1, output_permit=0. On start → WAIT_REQ with a fresh batch; done clears in the same cycle.
- Capture rule:
  - A line is pushed only when output_valid=1 and stall=0 in the same cycle. Upstream holds its outputs frozen while stalled, so capturing during stall would duplicate lines.
  - output_finish is sampled under the same stall=0 qualifier.
  - Lines with output_valid=0 (inter-group gaps) are never written.
- Stall:
  - Registered; asserted the cycle after fill ≥ FIFO_DEPTH−AF_MARGIN, deasserted the cycle after fill drops below the threshold.
  - Forced 0 outside STREAM/DRAIN.
  - FIFO overflow is impossible by construction; a push on full is an assertion error.
- Write issue:
  - When the FIFO is non-empty and wr_almost_full=0, pop the head into wr_req_data/wr_req_addr and pulse wr_req_valid for one cycle.
  - The address pointer then increments by 1, and lines_written and outstanding each increment by 1.
  - Issue latency: a line pushed at cycle t is requested no earlier than t+1.
  - At most one request per cycle.
- Outstanding counter: a simultaneous issue and wr_rsp_valid leaves it unchanged. wr_rsp_valid while the counter is 0 is ignored (saturates at 0).
- Simultaneous push and pop: fill is unchanged; this works at both full and empty.
- Address and counter wrap: the address pointer wraps modulo 2^ADDR_WIDTH with no error. lines_written saturates at all-ones.
- output_request deasserting after the grant has no effect.

Test Plan:
- Single read, mem_size=3 (header + 2 lines), base_addr=0x1000, host never full, responses after 5 cycles → 3 requests at 0x1000–0x1002 in order; lines_written=3; done=1 after the 3rd response.
- Upstream valid with gap cycles between 4 groups, 7 valid lines total → exactly 7 requests, no gap lines written, addresses contiguous.
- wr_almost_full held 1 for 100 cycles, 80-line stream, FIFO_DEPTH=64 → stall rises once fill reaches 56; no line is lost or duplicated during stall; 80 requests after release.
- Same-cycle issue and wr_rsp_valid with outstanding=5 → outstanding stays 5; done only after the final response.
- reset_n low mid-STREAM with 10 lines buffered → next cycle: wr_req_valid=0, stall=0, permit=0, FIFO empty; start pulse then runs a new batch cleanly.
- output_finish with no valid lines (batch_size 0) → DONE with lines_written=0 and no requests issued.

Source files
------------

// File: rtl/smem_result_writer_if.sv
// Upstream result-line handshake plus host cache-line write channel.
// The writer takes the master view; the surrounding environment takes the slave view.
interface smem_result_writer_if #(
  parameter int unsigned ADDR_WIDTH = 42
);
  logic                  output_request;
  logic                  output_permit;
  logic [511:0]          output_data;
  logic                  output_valid;
  logic                  output_finish;
  logic                  stall;
  logic                  wr_req_valid;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic [511:0]          wr_req_data;
  logic                  wr_almost_full;
  logic                  wr_rsp_valid;

  modport master (
    output output_permit, stall, wr_req_valid, wr_req_addr, wr_req_data,
    input  output_request, output_data, output_valid, output_finish,
           wr_almost_full, wr_rsp_valid
  );

  modport slave (
    input  output_permit, stall, wr_req_valid, wr_req_addr, wr_req_data,
    output output_request, output_data, output_valid, output_finish,
           wr_almost_full, wr_rsp_valid
  );
endinterface

// File: rtl/smem_result_writer.sv
// Result writer: grants the result RAM block its output permit, buffers the
// 512-bit result lines and writes them as sequential host cache lines.
module smem_result_writer #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned ADDR_WIDTH = 42,
  parameter int unsigned AF_MARGIN  = 8,
  parameter int unsigned CNT_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  smem_result_writer_if.master  bus,
  output logic [CNT_WIDTH-1:0]  lines_written_o,
  output logic                  done_o
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] STALL_THR = FILL_W'(FIFO_DEPTH - AF_MARGIN);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_REQ, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [511:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_q, rptr_q;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] aptr_q, aptr_d;
  logic [CNT_WIDTH-1:0]  lines_q, lines_d;
  logic [CNT_WIDTH-1:0]  outst_q, outst_d;
  logic                  stall_q, stall_d;
  logic                  req_valid_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [511:0]          req_data_q;

  logic active, push, pop, fin_cap, batch_start, rsp_take;

  // Handshake qualifiers; capture is gated by the registered stall because
  // upstream freezes (and would repeat) its outputs while stalled.
  always_comb begin
    active      = (state_q == S_STREAM) || (state_q == S_DRAIN);
    push        = (state_q == S_STREAM) && bus.output_valid && !stall_q;
    fin_cap     = (state_q == S_STREAM) && bus.output_finish && !stall_q;
    pop         = active && (fill_q != '0) && !bus.wr_almost_full;
    batch_start = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    rsp_take    = bus.wr_rsp_valid && (outst_q != '0);
  end

  // Batch sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (start_i) state_d = S_WAIT_REQ;
      S_WAIT_REQ: if (bus.output_request) state_d = S_STREAM;
      S_STREAM:   if (fin_cap) state_d = S_DRAIN;
      S_DRAIN:    if ((fill_q == '0) && (outst_q == '0)) state_d = S_DONE;
      S_DONE:     if (start_i) state_d = S_WAIT_REQ;
      default:    state_d = S_IDLE;
    endcase
  end

  // Fill, address, line and outstanding-write bookkeeping.
  always_comb begin
    fill_d  = fill_q;
    aptr_d  = aptr_q;
    lines_d = lines_q;
    outst_d = outst_q;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
    // An issue is counted at the pop edge, so a response in that same cycle
    // always belongs to an earlier request.
    unique case ({pop, rsp_take})
      2'b10:   outst_d = outst_q + CNT_WIDTH'(1);
      2'b01:   outst_d = outst_q - CNT_WIDTH'(1);
      default: outst_d = outst_q;
    endcase
    if (pop) begin
      aptr_d = aptr_q + ADDR_WIDTH'(1);
      if (lines_q != '1) lines_d = lines_q + CNT_WIDTH'(1);
    end
    if (batch_start) begin
      aptr_d  = base_addr_i;
      lines_d = '0;
      outst_d = '0;
    end
    stall_d = active && (fill_q >= STALL_THR);
  end

  // Control and request registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fill_q      <= '0;
      aptr_q      <= '0;
      lines_q     <= '0;
      outst_q     <= '0;
      stall_q     <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      aptr_q      <= aptr_d;
      lines_q     <= lines_d;
      outst_q     <= outst_d;
      stall_q     <= stall_d;
      req_valid_q <= pop;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop) begin
        rptr_q     <= rptr_q + PTR_W'(1);
        req_addr_q <= aptr_q;
        req_data_q <= mem_q[rptr_q];
      end
    end
  end

  // Line storage; emptiness is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.output_data;
  end

  // The stall margin must make a push into a full buffer unreachable.
  always_ff @(posedge clk) begin
    if (reset_n) assert (!(push && !pop && (fill_q == FILL_MAX)));
  end

  assign bus.output_permit = active;
  assign bus.stall         = stall_q;
  assign bus.wr_req_valid  = req_valid_q;
  assign bus.wr_req_addr   = req_addr_q;
  assign bus.wr_req_data   = req_data_q;
  assign lines_written_o   = lines_q;
  assign done_o            = (state_q == S_DONE);
endmodule

// File: tb/tb_smem_result_writer.sv
// Directed bench for smem_result_writer with a host write/response model.
module tb_smem_result_writer;
  localparam int unsigned AW = 42;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [19:0]   lines_written;
  logic          done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  smem_result_writer_if #(.ADDR_WIDTH(AW)) bus ();

  smem_result_writer #(
    .FIFO_DEPTH(64),
    .ADDR_WIDTH(AW),
    .AF_MARGIN(8),
    .CNT_WIDTH(20)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_i        (start),
    .base_addr_i    (base_addr),
    .bus            (bus),
    .lines_written_o(lines_written),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  // Host model: records requests, answers each one 5 cycles later in auto mode.
  logic [AW-1:0] req_addr [$];
  logic [511:0]  req_data [$];
  int unsigned   due [$];
  int unsigned   cyc = 0;
  int unsigned   rsp_cnt = 0;
  bit            rsp_auto = 1'b1;
  logic          rsp_auto_v = 1'b0;
  logic          rsp_man = 1'b0;

  assign bus.wr_rsp_valid = rsp_auto_v | rsp_man;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      rsp_auto_v = 1'b0;
      if (reset_n !== 1'b1) begin
        due.delete();
      end else begin
        if (bus.wr_req_valid === 1'b1) begin
          req_addr.push_back(bus.wr_req_addr);
          req_data.push_back(bus.wr_req_data);
          if (rsp_auto) due.push_back(cyc + 5);
        end
        if (rsp_auto && due.size() > 0 && due[0] <= cyc) begin
          void'(due.pop_front());
          rsp_auto_v = 1'b1;
          rsp_cnt++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  function automatic logic [511:0] mk(input int unsigned tag, input int unsigned i);
    return {16{tag[15:0], i[15:0]}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic open_batch(input logic [AW-1:0] a);
    int unsigned b = 0;
    req_addr.delete();
    req_data.delete();
    rsp_cnt = 0;
    base_addr = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.output_request = 1'b1;
    while (bus.output_permit !== 1'b1 && b < 20) begin tick(); b++; end
    chk("permit_granted", bus.output_permit, 1);
    bus.output_request = 1'b0;
  endtask

  task automatic send_line(input logic [511:0] d, input logic fin);
    int unsigned b = 0;
    bus.output_valid  = 1'b1;
    bus.output_data   = d;
    bus.output_finish = fin;
    while (bus.stall === 1'b1 && b < 500) begin tick(); b++; end
    chk("send_stall_bound", b < 500, 1);
    tick();
    bus.output_valid  = 1'b0;
    bus.output_finish = 1'b0;
  endtask

  task automatic send_finish();
    int unsigned b = 0;
    bus.output_finish = 1'b1;
    while (bus.stall === 1'b1 && b < 500) begin tick(); b++; end
    chk("finish_stall_bound", b < 500, 1);
    tick();
    bus.output_finish = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    int unsigned b = 0;
    while (done !== 1'b1 && b < budget) begin tick(); b++; end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic check_seq(input string tag, input logic [AW-1:0] base,
                           input int unsigned tagid, input int unsigned n);
    int unsigned   bad = 0;
    logic [AW-1:0] ea;
    ea = base;
    chk({tag, "_req_count"}, req_addr.size(), n);
    for (int unsigned i = 0; i < n && i < req_addr.size(); i++) begin
      if (req_addr[i] !== ea || req_data[i] !== mk(tagid, i)) bad++;
      ea = ea + AW'(1);
    end
    chk({tag, "_addr_data_order_errs"}, bad, 0);
  endtask

  initial begin
    int unsigned i;
    int unsigned k;
    int unsigned b;
    int unsigned gsz [4];
    gsz = '{1, 2, 3, 1};

    reset_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    bus.output_request = 1'b0;
    bus.output_data = '0;
    bus.output_valid = 1'b0;
    bus.output_finish = 1'b0;
    bus.wr_almost_full = 1'b0;
    tick(3);

    // reset state
    chk("rst_permit", bus.output_permit, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_req_valid", bus.wr_req_valid, 0);
    chk("rst_req_addr", bus.wr_req_addr, 0);
    chk("rst_req_data", bus.wr_req_data, 0);
    chk("rst_lines", lines_written, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    tick();

    // header + 2 lines at 0x1000
    open_batch(AW'('h1000));
    send_line(mk(1, 0), 1'b0);
    send_line(mk(1, 1), 1'b0);
    send_line(mk(1, 2), 1'b1);
    wait_done("t1", 100);
    chk("t1_rsp_before_done", rsp_cnt, 3);
    check_seq("t1", AW'('h1000), 1, 3);
    chk("t1_lines", lines_written, 3);

    // 4 groups separated by gaps, 7 valid lines, fresh batch from DONE
    open_batch(AW'('h2000));
    k = 0;
    for (int unsigned g = 0; g < 4; g++) begin
      for (int unsigned j = 0; j < gsz[g]; j++) begin
        send_line(mk(2, k), k == 6);
        k++;
      end
      bus.output_data = mk(16'hBAD, g);
      tick(2);
    end
    wait_done("t2", 100);
    check_seq("t2", AW'('h2000), 2, 7);
    chk("t2_lines", lines_written, 7);

    // host back-pressure: 80-line stream with the channel blocked
    bus.wr_almost_full = 1'b1;
    open_batch(AW'('h3000));
    i = 0;
    b = 0;
    while (i < 80 && b < 200) begin
      bus.output_valid = 1'b1;
      bus.output_data = mk(3, i);
      if (bus.stall === 1'b1) break;
      tick();
      i++;
      b++;
    end
    chk("t3_lines_accepted_before_stall", i, 57);
    tick(40);
    chk("t3_stall_held", bus.stall, 1);
    chk("t3_no_req_while_full", req_addr.size(), 0);
    bus.wr_almost_full = 1'b0;
    while (i < 80) begin
      send_line(mk(3, i), i == 79);
      i++;
    end
    wait_done("t3", 500);
    check_seq("t3", AW'('h3000), 3, 80);
    chk("t3_lines", lines_written, 80);

    // simultaneous issue and response with 5 outstanding; stray response at 0
    rsp_auto = 1'b0;
    open_batch(AW'('h4000));
    rsp_man = 1'b1;
    tick();
    rsp_man = 1'b0;
    for (int unsigned j = 0; j < 5; j++) send_line(mk(4, j), 1'b0);
    b = 0;
    while (req_addr.size() < 5 && b < 50) begin tick(); b++; end
    chk("t4_first_five_issued", req_addr.size(), 5);
    bus.wr_almost_full = 1'b1;
    send_line(mk(4, 5), 1'b0);
    tick();
    bus.wr_almost_full = 1'b0;
    rsp_man = 1'b1;
    tick();
    rsp_man = 1'b0;
    send_finish();
    tick(3);
    chk("t4_req_count", req_addr.size(), 6);
    chk("t4_not_done_outstanding5", done, 0);
    for (int unsigned r = 0; r < 4; r++) begin
      rsp_man = 1'b1;
      tick();
      rsp_man = 1'b0;
      tick(2);
    end
    chk("t4_not_done_outstanding1", done, 0);
    rsp_man = 1'b1;
    tick();
    rsp_man = 1'b0;
    wait_done("t4", 10);
    check_seq("t4", AW'('h4000), 4, 6);
    chk("t4_lines", lines_written, 6);
    rsp_auto = 1'b1;

    // reset mid-STREAM with 10 lines buffered
    bus.wr_almost_full = 1'b1;
    open_batch(AW'('h5000));
    for (int unsigned j = 0; j < 10; j++) send_line(mk(5, j), 1'b0);
    tick();
    chk("t5_stall_below_thr", bus.stall, 0);
    chk("t5_permit_streaming", bus.output_permit, 1);
    reset_n = 1'b0;
    tick();
    chk("t5_rst_req_valid", bus.wr_req_valid, 0);
    chk("t5_rst_stall", bus.stall, 0);
    chk("t5_rst_permit", bus.output_permit, 0);
    chk("t5_rst_lines", lines_written, 0);
    reset_n = 1'b1;
    bus.wr_almost_full = 1'b0;
    tick(20);
    chk("t5_fifo_flushed", req_addr.size(), 0);
    open_batch(AW'('h6000));
    send_line(mk(6, 0), 1'b0);
    send_line(mk(6, 1), 1'b1);
    wait_done("t5", 100);
    check_seq("t5", AW'('h6000), 6, 2);

    // empty batch
    open_batch(AW'('h7000));
    send_finish();
    wait_done("t6", 50);
    chk("t6_lines", lines_written, 0);
    tick(8);
    chk("t6_req_count", req_addr.size(), 0);

    // address wrap at the top of the space
    open_batch('1);
    send_line(mk(7, 0), 1'b0);
    send_line(mk(7, 1), 1'b1);
    wait_done("t7", 100);
    check_seq("t7", '1, 7, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
